// File: rtl/fp_mac_pkg.sv
// rtl/fp_mac_pkg.sv - shared widths, constants and packed-single type for the MAC adder
package fp_mac_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int SUM_W  = 25;
  localparam int LZC_W  = 5;
  localparam int EXPI_W = 10;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/lzc24.sv
// rtl/lzc24.sv - combinational leading-zero counter over 24 bits
module lzc24
  import fp_mac_pkg::*;
(
  input  logic [23:0]      d_i,
  output logic [LZC_W-1:0] cnt_o,
  output logic             zero_o
);

  // Later (higher) set bits overwrite earlier ones, so the MSB one wins.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 24; i++) begin
      if (d_i[i]) cnt_o = LZC_W'(23 - i);
    end
  end

  assign zero_o = ~|d_i;

endmodule

// File: rtl/fp_add_normalize.sv
// rtl/fp_add_normalize.sv - normalize, round-to-nearest-even and pack stage of the FP adder
module fp_add_normalize
  import fp_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] mxy,
  input  logic [EXP_W-1:0] ex,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             uf
);

  logic                     s1_valid_q;
  logic [LZC_W-1:0]         s1_lzc_q, s1_lzc_d;
  logic [23:0]              s1_mant_q, s1_mant_d;
  logic                     s1_rnd_q, s1_rnd_d;
  logic signed [EXPI_W-1:0] s1_exp_q, s1_exp_d;
  logic                     s1_sgn_q, s1_sgn_d;
  logic                     s1_zero_q, s1_zero_d;
  logic                     s1_inf_q, s1_inf_d;

  logic                     out_valid_q;
  fp32_t                    result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     uf_q, uf_d;

  logic                     adv1, adv2;
  logic [LZC_W-1:0]         lzc;
  logic                     lz_zero;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  lzc24 u_lzc (
    .d_i    (mxy[23:0]),
    .cnt_o  (lzc),
    .zero_o (lz_zero)
  );

  // The leading-zero count is subtracted from the exponent in S2, keeping
  // the S1 path to the count plus the shifter.
  always_comb begin
    s1_zero_d = !mxy[SUM_W-1] && lz_zero;
    s1_inf_d  = (ex == EXP_MAX);
    s1_sgn_d  = s1_zero_d ? 1'b0 : sgn;
    if (mxy[SUM_W-1]) begin
      s1_mant_d = mxy[24:1];
      s1_rnd_d  = mxy[0];
      s1_exp_d  = $signed({2'b00, ex}) + 10'sd1;
      s1_lzc_d  = '0;
    end else begin
      s1_mant_d = mxy[23:0] << lzc;
      s1_rnd_d  = 1'b0;
      s1_exp_d  = $signed({2'b00, ex});
      s1_lzc_d  = lzc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lzc_q   <= '0;
      s1_mant_q  <= '0;
      s1_rnd_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_sgn_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_lzc_q  <= s1_lzc_d;
        s1_mant_q <= s1_mant_d;
        s1_rnd_q  <= s1_rnd_d;
        s1_exp_q  <= s1_exp_d;
        s1_sgn_q  <= s1_sgn_d;
        s1_zero_q <= s1_zero_d;
        s1_inf_q  <= s1_inf_d;
      end
    end
  end

  logic [24:0]              mant_rnd;
  logic signed [EXPI_W-1:0] exp_n;
  logic                     unused_hidden;

  assign mant_rnd      = {1'b0, s1_mant_q} + 25'(s1_rnd_q & s1_mant_q[0]);
  assign exp_n         = s1_exp_q - $signed({5'b00000, s1_lzc_q})
                         + (mant_rnd[24] ? 10'sd1 : 10'sd0);
  assign unused_hidden = mant_rnd[23];

  // Tags take priority over range checks: an inf input never raises ovf.
  always_comb begin
    result_d.sign = s1_sgn_q;
    result_d.exp  = exp_n[7:0];
    result_d.frac = mant_rnd[24] ? 23'h0 : mant_rnd[22:0];
    ovf_d         = 1'b0;
    uf_d          = 1'b0;
    if (s1_zero_q) begin
      result_d = ZERO;
    end else if (s1_inf_q) begin
      result_d      = INF;
      result_d.sign = s1_sgn_q;
    end else if (exp_n >= 10'sd255) begin
      result_d      = INF;
      result_d.sign = s1_sgn_q;
      ovf_d         = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      result_d      = ZERO;
      result_d.sign = s1_sgn_q;
      uf_d          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      uf_q        <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        uf_q     <= uf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign uf        = uf_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// tb/tb_fp_add_normalize.sv - randomized bench with a behavioural reference model and scoreboard
module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mxy;
  logic [7:0]  ex;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        uf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_add_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mxy       (mxy),
    .ex        (ex),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .uf        (uf)
  );

  // Returns {ovf, uf, result} from the value-level rules of the stage.
  function automatic logic [33:0] model(input logic [24:0] m_in, input logic [7:0] e_in, input logic s_in);
    longint m;
    int     e;
    bit     rb;
    if (m_in == 0) return 34'h0;
    if (e_in == 8'hFF) return {2'b00, s_in, 8'hFF, 23'h0};
    m  = m_in;
    e  = e_in;
    rb = 0;
    if (m >= 64'd16777216) begin
      rb = (m % 2) == 1;
      m  = m / 2;
      e  = e + 1;
    end else begin
      while (m < 64'd8388608) begin
        m = m * 2;
        e = e - 1;
      end
    end
    if (rb && (m % 2) == 1) m = m + 1;
    if (m == 64'd16777216) begin
      m = m / 2;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, s_in, 8'hFF, 23'h0};
    if (e <= 0)   return {2'b01, s_in, 31'h0};
    return {2'b00, s_in, e[7:0], m[22:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic [24:0] m, input logic [7:0] e, input logic s);
    bit acc;
    int n;
    in_valid = 1'b1;
    mxy      = m;
    ex       = e;
    sgn      = s;
    acc      = 0;
    n        = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout actual=no_accept expected=accept");
    end
  endtask

  logic [33:0] exp_q[$];
  bit          prev_stall;
  logic [34:0] prev_out;

  always @(negedge clk) begin
    logic [33:0] e_v;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_hold", {29'h0, out_valid, ovf, uf, result}, {29'h0, prev_out});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {30'h0, ovf, uf, result}, 64'hDEAD);
        end else begin
          e_v = exp_q.pop_front();
          chk("scoreboard", {30'h0, ovf, uf, result}, {30'h0, e_v});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(mxy, ex, sgn));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, ovf, uf, result};
    end
  end

  logic [24:0] d_mxy[8];
  logic [7:0]  d_ex[8];
  logic        d_sgn[8];
  logic [33:0] d_exp[8];
  logic [24:0] bp_mxy[4];
  bit          done;
  int          k;
  int          n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d_mxy = '{25'h0800000, 25'h1000003, 25'h1000001, 25'h0000001, 25'h0000000, 25'h1FFFFFF, 25'h0000100, 25'h0400000};
    d_ex  = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd254, 8'd10, 8'd127};
    d_sgn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d_exp = '{{2'b00, 32'h3F80_0000}, {2'b00, 32'h4000_0002}, {2'b00, 32'h4000_0000}, {2'b00, 32'h3400_0000},
              {2'b00, 32'h0000_0000}, {2'b10, 32'h7F80_0000}, {2'b01, 32'h8000_0000}, {2'b00, 32'h3F00_0000}};
    bp_mxy = '{25'h0812345, 25'h1ABCDEF, 25'h0000777, 25'h0FFFFFF};

    rst_n = 1'b0; in_valid = 1'b0; mxy = '0; ex = '0; sgn = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {28'h0, out_valid, in_ready, ovf, uf, result}, {28'h0, 4'b0100, 32'h0});
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) chk($sformatf("model_pin%0d", i), {30'h0, model(d_mxy[i], d_ex[i], d_sgn[i])}, {30'h0, d_exp[i]});
    chk("model_pin_inf", {30'h0, model(25'h0800000, 8'hFF, 1'b1)}, {30'h0, 34'h0_FF80_0000});

    drive(d_mxy[0], d_ex[0], d_sgn[0]);
    chk("latency_edge1", {63'h0, out_valid}, 64'h0);
    @(posedge clk); #1;
    chk("latency_edge2", {29'h0, out_valid, ovf, uf, result}, {29'h0, 3'b100, 32'h3F80_0000});
    for (int i = 1; i < 8; i++) drive(d_mxy[i], d_ex[i], d_sgn[i]);
    drive(25'h0800000, 8'hFF, 1'b1);
    repeat (3) begin @(posedge clk); #1; end

    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; mxy = bp_mxy[k]; ex = 8'd100; sgn = 1'b0;
      @(negedge clk);
      if (in_ready) k++;
      @(posedge clk); #1;
    end
    chk("bp_accepts", 64'(k), 64'd2);
    chk("bp_in_ready_low", {63'h0, in_ready}, 64'h0);
    out_ready = 1'b1;
    while (k < 4) begin
      drive(bp_mxy[k], 8'd100, 1'b0);
      k++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    out_ready = 1'b0;
    drive(25'h0C00000, 8'd50, 1'b1);
    drive(25'h1800001, 8'd60, 1'b0);
    chk("rst_pipe_full", {62'h0, out_valid, in_ready}, 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", {30'h0, out_valid, ovf, result[31:0]}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", {63'h0, out_valid}, 64'h0);
    end
    drive(25'h0A00000, 8'd140, 1'b1);
    chk("rst_relat_edge1", {63'h0, out_valid}, 64'h0);
    @(posedge clk); #1;
    chk("rst_relat_edge2", {29'h0, out_valid, ovf, uf, result}, {29'h0, 1'b1, model(25'h0A00000, 8'd140, 1'b1)});

    done = 0;
    fork
      begin
        for (int t = 0; t < 400; t++) begin
          logic [24:0] rm;
          logic [7:0]  re;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          case ($urandom_range(0, 4))
            0: rm = {1'b1, 24'($urandom)};
            1: rm = {2'b01, 23'($urandom)};
            2: rm = 25'($urandom) >> $urandom_range(2, 24);
            3: rm = 25'h0;
            default: rm = 25'($urandom);
          endcase
          case ($urandom_range(0, 3))
            0: re = 8'($urandom);
            1: re = 8'($urandom_range(0, 30));
            2: re = 8'($urandom_range(230, 255));
            default: re = 8'($urandom_range(120, 135));
          endcase
          drive(rm, re, 1'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
